// File: rtl/fetch_ifid.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, handles stall, branch redirect and HALT.
// Optional stall-cycle counter port enabled by defining FETCH_STALL_CNT_EN.
module fetch_ifid #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallCtrl,
    input  logic        takeBranch,
    input  logic [15:0] branchTarget,
    input  logic [15:0] imemData,
    input  logic        imemValid,
    output logic [15:0] imemAddr,
    output logic [15:0] instr_IFID,
    output logic [15:0] pcPlus2_IFID,
    output logic        valid_IFID,
    output logic [2:0]  Rd1Addr_IFID,
    output logic [2:0]  Rd2Addr_IFID,
    output logic        halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stallCount
`endif
);

    typedef enum logic {RUN, HALTED} fetchState_t;

    fetchState_t state, stateNext;
    logic [15:0] pc, pcNext;
    logic [15:0] instrNext, pcPlus2Next;
    logic        validNext;
    logic [15:0] pcPlus2;
    logic        isHalt;

    assign pcPlus2 = pc + 16'd2;
    assign isHalt  = (imemData[15:11] == 5'b00000);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        stateNext   = state;
        pcNext      = pc;
        instrNext   = instr_IFID;
        pcPlus2Next = pcPlus2_IFID;
        validNext   = valid_IFID;

        if (takeBranch) begin
            pcNext      = branchTarget & 16'hFFFE;
            instrNext   = NOP_INSTR;
            pcPlus2Next = 16'h0000;
            validNext   = 1'b0;
            stateNext   = RUN;
        end else if (stallCtrl) begin
            // Full hold, including while halted: no bubble is injected.
        end else if (state == HALTED || !imemValid) begin
            instrNext   = NOP_INSTR;
            pcPlus2Next = 16'h0000;
            validNext   = 1'b0;
        end else begin
            instrNext   = imemData;
            pcPlus2Next = pcPlus2;
            validNext   = 1'b1;
            pcNext      = pcPlus2 & 16'hFFFE;
            if (isHalt) stateNext = HALTED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            pc           <= RESET_PC;
            instr_IFID   <= NOP_INSTR;
            pcPlus2_IFID <= 16'h0000;
            valid_IFID   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from pre-edge values.
            state        <= stateNext;
            pc           <= pcNext;
            instr_IFID   <= instrNext;
            pcPlus2_IFID <= pcPlus2Next;
            valid_IFID   <= validNext;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Counts only stalls that actually freeze fetch; a concurrent redirect wins over the stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= 16'h0000;
        end else if (stallCtrl && !takeBranch && stallCount != 16'hFFFF) begin
            stallCount <= stallCount + 16'd1;
        end
    end
`endif

    assign imemAddr     = pc;
    assign halted       = (state == HALTED);
    assign Rd1Addr_IFID = instr_IFID[10:8];
    assign Rd2Addr_IFID = instr_IFID[7:5];

endmodule

// File: tb/tb_fetch_ifid.sv
// Self-checking bench for fetch_ifid: directed scenarios plus randomized traffic against a cycle-level model.
module tb_fetch_ifid;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallCtrl;
    logic        takeBranch;
    logic [15:0] branchTarget;
    logic [15:0] imemData;
    logic        imemValid;
    logic [15:0] imemAddr;
    logic [15:0] instr_IFID;
    logic [15:0] pcPlus2_IFID;
    logic        valid_IFID;
    logic [2:0]  Rd1Addr_IFID;
    logic [2:0]  Rd2Addr_IFID;
    logic        halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stallCount;
`endif

    int passCnt  = 0;
    int totalCnt = 0;

    // Reference model state (plain integers / words)
    int          mPc;
    logic [15:0] mInstr;
    int          mPcPlus2;
    logic        mValid;
    logic        mHalted;
    int          mStalls;

    localparam logic [55:0] RESET_VEC = {16'h0000, 16'h0800, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0};

    fetch_ifid dut (
        .clk          (clk),
        .rst          (rst),
        .stallCtrl    (stallCtrl),
        .takeBranch   (takeBranch),
        .branchTarget (branchTarget),
        .imemData     (imemData),
        .imemValid    (imemValid),
        .imemAddr     (imemAddr),
        .instr_IFID   (instr_IFID),
        .pcPlus2_IFID (pcPlus2_IFID),
        .valid_IFID   (valid_IFID),
        .Rd1Addr_IFID (Rd1Addr_IFID),
        .Rd2Addr_IFID (Rd2Addr_IFID),
        .halted       (halted)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stallCount   (stallCount)
`endif
    );

    always #5 clk = ~clk;

    wire [55:0] obsVec = {imemAddr, instr_IFID, pcPlus2_IFID, valid_IFID,
                          Rd1Addr_IFID, Rd2Addr_IFID, halted};

    function automatic logic [55:0] expVec();
        logic [15:0] pcW, p2W;
        pcW = 16'(mPc);
        p2W = 16'(mPcPlus2);
        return {pcW, mInstr, p2W, mValid, mInstr[10:8], mInstr[7:5], mHalted};
    endfunction

    task automatic modelReset();
        mPc      = 0;
        mInstr   = 16'h0800;
        mPcPlus2 = 0;
        mValid   = 1'b0;
        mHalted  = 1'b0;
        mStalls  = 0;
    endtask

    task automatic modelBubble();
        mInstr   = 16'h0800;
        mPcPlus2 = 0;
        mValid   = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, leave time at posedge+1.
    task automatic step(input logic st, input logic br, input logic [15:0] tgt,
                        input logic iv, input logic [15:0] data);
        stallCtrl    = st;
        takeBranch   = br;
        branchTarget = tgt;
        imemValid    = iv;
        imemData     = data;
        @(posedge clk);
        if (br) begin
            mPc     = int'(tgt) & 32'hFFFE;
            mHalted = 1'b0;
            modelBubble();
        end else if (st) begin
            mPc = mPc;
        end else if (mHalted || !iv) begin
            modelBubble();
        end else begin
            mInstr   = data;
            mPcPlus2 = (mPc + 2) % 65536;
            mValid   = 1'b1;
            mPc      = mPcPlus2;
            if (data[15:11] == 5'b00000) mHalted = 1'b1;
        end
        if (st && !br && mStalls < 65535) mStalls++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stallCtrl = 0; takeBranch = 0; branchTarget = 0; imemValid = 0; imemData = 0;
        modelReset();
        #12;
        totalCnt++;
        if (obsVec !== RESET_VEC) $display("FAIL reset_state: got %h want %h", obsVec, RESET_VEC);
        else passCnt++;
`ifdef FETCH_STALL_CNT_EN
        totalCnt++;
        if (stallCount !== 16'h0000) $display("FAIL reset_stallCount: got %h want 0000", stallCount);
        else passCnt++;
`endif
        rst = 1'b0;
    endtask

    task automatic test_straight_line();
        logic [15:0] want [3] = '{16'h4000, 16'h4001, 16'h4002};
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 16'h4000 + 16'(mPc / 2));
            totalCnt++;
            if ({instr_IFID, pcPlus2_IFID, valid_IFID} !== {want[i], 16'(2 * (i + 1)), 1'b1})
                $display("FAIL straight_%0d: got instr=%h pc2=%h v=%b want instr=%h pc2=%h v=1",
                         i, instr_IFID, pcPlus2_IFID, valid_IFID, want[i], 16'(2 * (i + 1)));
            else passCnt++;
        end
    endtask

    task automatic test_stall();
        logic [55:0] held;
        held = obsVec;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 16'h7777);
            totalCnt++;
            if (obsVec !== held || imemAddr !== 16'h0006)
                $display("FAIL stall_hold_%0d: got %h want %h", i, obsVec, held);
            else passCnt++;
        end
`ifdef FETCH_STALL_CNT_EN
        totalCnt++;
        if (stallCount !== 16'd3) $display("FAIL stallCount_3: got %0d want 3", stallCount);
        else passCnt++;
`endif
        step(0, 0, 0, 1, 16'h4003);
        totalCnt++;
        if ({instr_IFID, pcPlus2_IFID, imemAddr} !== {16'h4003, 16'h0008, 16'h0008})
            $display("FAIL stall_resume: got instr=%h pc2=%h addr=%h want 4003 0008 0008",
                     instr_IFID, pcPlus2_IFID, imemAddr);
        else passCnt++;
    endtask

    task automatic test_branch_stall();
        step(1, 1, 16'h0101, 1, 16'h4004);
        totalCnt++;
        if ({imemAddr, valid_IFID, instr_IFID} !== {16'h0100, 1'b0, 16'h0800})
            $display("FAIL branch_over_stall: got addr=%h v=%b instr=%h want 0100 0 0800",
                     imemAddr, valid_IFID, instr_IFID);
        else passCnt++;
`ifdef FETCH_STALL_CNT_EN
        totalCnt++;
        if (stallCount !== 16'd3) $display("FAIL branch_no_count: got %0d want 3", stallCount);
        else passCnt++;
`endif
    endtask

    task automatic test_halt();
        step(0, 0, 0, 1, 16'h0000);
        totalCnt++;
        if ({instr_IFID, valid_IFID, halted, imemAddr} !== {16'h0000, 1'b1, 1'b1, 16'h0102})
            $display("FAIL halt_capture: got instr=%h v=%b h=%b addr=%h want 0000 1 1 0102",
                     instr_IFID, valid_IFID, halted, imemAddr);
        else passCnt++;
        step(1, 0, 0, 1, 16'h4444);
        totalCnt++;
        if ({instr_IFID, valid_IFID, halted} !== {16'h0000, 1'b1, 1'b1})
            $display("FAIL halt_stall_hold: got instr=%h v=%b h=%b want 0000 1 1",
                     instr_IFID, valid_IFID, halted);
        else passCnt++;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 1, 16'h4444);
            totalCnt++;
            if (obsVec !== expVec() || valid_IFID !== 1'b0 || imemAddr !== 16'h0102)
                $display("FAIL halt_bubble_%0d: got %h want %h", i, obsVec, expVec());
            else passCnt++;
        end
        step(0, 1, 16'h0020, 1, 16'h4444);
        totalCnt++;
        if ({halted, imemAddr} !== {1'b0, 16'h0020})
            $display("FAIL halt_restart: got h=%b addr=%h want 0 0020", halted, imemAddr);
        else passCnt++;
        step(0, 1, 16'h0040, 1, 16'h0000);
        totalCnt++;
        if ({halted, valid_IFID, imemAddr} !== {1'b0, 1'b0, 16'h0040})
            $display("FAIL branch_discards_halt: got h=%b v=%b addr=%h want 0 0 0040",
                     halted, valid_IFID, imemAddr);
        else passCnt++;
    endtask

    task automatic test_gap_wrap();
        step(0, 1, 16'hFFFF, 1, 16'h4000);
        totalCnt++;
        if (imemAddr !== 16'hFFFE) $display("FAIL target_bit0: got %h want fffe", imemAddr);
        else passCnt++;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 16'h1234);
            totalCnt++;
            if ({imemAddr, valid_IFID, instr_IFID} !== {16'hFFFE, 1'b0, 16'h0800})
                $display("FAIL gap_bubble_%0d: got addr=%h v=%b instr=%h want fffe 0 0800",
                         i, imemAddr, valid_IFID, instr_IFID);
            else passCnt++;
        end
        step(0, 0, 0, 1, 16'h4ABC);
        totalCnt++;
        if ({pcPlus2_IFID, imemAddr, instr_IFID, Rd1Addr_IFID, Rd2Addr_IFID} !==
            {16'h0000, 16'h0000, 16'h4ABC, 3'd2, 3'd5})
            $display("FAIL wrap_fetch: got pc2=%h addr=%h instr=%h rd1=%0d rd2=%0d want 0000 0000 4abc 2 5",
                     pcPlus2_IFID, imemAddr, instr_IFID, Rd1Addr_IFID, Rd2Addr_IFID);
        else passCnt++;
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 1, 16'h5F00);
        #2;
        rst = 1'b1;
        #1;
        totalCnt++;
        if (obsVec !== RESET_VEC) $display("FAIL async_reset: got %h want %h", obsVec, RESET_VEC);
        else passCnt++;
`ifdef FETCH_STALL_CNT_EN
        totalCnt++;
        if (stallCount !== 16'h0000) $display("FAIL async_reset_cnt: got %h want 0000", stallCount);
        else passCnt++;
`endif
        modelReset();
        #3;
        rst = 1'b0;
        step(0, 0, 0, 1, 16'h4000);
        totalCnt++;
        if ({instr_IFID, pcPlus2_IFID, valid_IFID} !== {16'h4000, 16'h0002, 1'b1})
            $display("FAIL post_reset_fetch: got instr=%h pc2=%h v=%b want 4000 0002 1",
                     instr_IFID, pcPlus2_IFID, valid_IFID);
        else passCnt++;
    endtask

    task automatic test_random();
        logic        st, br, iv;
        logic [15:0] tgt, data;
        for (int i = 0; i < 400; i++) begin
            st   = ($urandom_range(0, 3) == 0);
            br   = ($urandom_range(0, 9) == 0);
            iv   = ($urandom_range(0, 4) != 0);
            tgt  = 16'($urandom);
            data = 16'($urandom);
            if ($urandom_range(0, 7) == 0) data = data & 16'h07FF;
            step(st, br, tgt, iv, data);
            totalCnt++;
            if (obsVec !== expVec())
                $display("FAIL random_%0d: got %h want %h (addr,instr,pc2,valid,rd1,rd2,halted)",
                         i, obsVec, expVec());
            else passCnt++;
`ifdef FETCH_STALL_CNT_EN
            totalCnt++;
            if (stallCount !== 16'(mStalls))
                $display("FAIL random_cnt_%0d: got %0d want %0d", i, stallCount, mStalls);
            else passCnt++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_stall();
        test_branch_stall();
        test_halt();
        test_gap_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
